avalon16_cmd_fifo: RTL
======================

# avalon16_cmd_fifo

Buffered Avalon-MM 16-bit command stage between the Wishbone-to-Avalon bridge (upstream master) and the SDRAM controller (downstream slave). It absorbs controller stalls in an in-order command FIFO and tracks outstanding reads. It returns read data to the bridge through a registered response path. Both sides use the active-low read/write/byteenable signalling of the SDRAM controller and run on one clock.

## Interface
Parameters:
- DEPTH, 4 — FIFO entries; power of two, ≥2
- MAX_RD, 4 — maximum outstanding reads (queued + in flight at controller), 1..15

Ports:
- sdram_clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- s_address  in  22  upstream word address
- s_byteenable_n  in  2  upstream byte enables, active-low
- s_chipselect  in  1  upstream chip select
- s_read_n  in  1  upstream read request, active-low
- s_write_n  in  1  upstream write request, active-low
- s_writedata  in  16  upstream write data
- s_waitrequest  out  1  stall to upstream
- s_readdata  out  16  read data to upstream
- s_readdatavalid  out  1  read data strobe to upstream
- m_address  out  22  to controller
- m_byteenable_n  out  2  to controller
- m_chipselect  out  1  to controller
- m_read_n  out  1  to controller
- m_write_n  out  1  to controller
- m_writedata  out  16  to controller
- m_waitrequest  in  1  controller stall
- m_readdata  in  16  controller read data
- m_readdatavalid  in  1  controller read strobe

## Operation
- Request: s_chipselect=1 and (s_read_n=0 or s_write_n=0). Both low: treated as a write; the read is dropped.
- Entry stores {is_write, address, byteenable_n, writedata}; writedata is stored as 0 for reads.
- s_waitrequest = reset active OR full OR (request is read AND rd_out == MAX_RD). This is a combinational function of registered state and s_* inputs only. There is no path from m_waitrequest.
- Push on an edge where a request is present and s_waitrequest=0. The upstream master deasserts the request after one accepted cycle; a request held low for N unstalled cycles pushes N entries.
- Head presentation when not empty: m_chipselect=1; m_read_n=is_write; m_write_n=~is_write; address, byteenable_n and writedata come from the head entry.
- Empty: m_chipselect=0, m_read_n=1, m_write_n=1, m_byteenable_n=2'b11; address and writedata hold their last values.
- Pop on an edge where the FIFO is not empty and m_waitrequest=0.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full when the MSBs differ and the LSBs are equal. Empty when the pointers are equal.
- rd_out counter:
  - +1 on a read push.
  - −1 when s_readdatavalid=1.
  - Both in the same edge: unchanged.
  - Decrement at 0: stays 0, no underflow. The strobe is still forwarded.
- Response path: s_readdatavalid <= m_readdatavalid; s_readdata <= m_readdata when m_readdatavalid=1, otherwise hold.

## Timing
- Reset values: FIFO empty, rd_out=0, s_readdatavalid=0, s_readdata=0, m_address=0, m_writedata=0, m_byteenable_n=2'b11, m_read_n=1, m_write_n=1, m_chipselect=0. s_waitrequest=1 while reset_n=0.
- Reset mid-transfer: queued entries are discarded. Late controller responses after reset are forwarded but do not underflow rd_out.
- Command latency: push at edge N, entry visible on m_* after edge N, earliest pop at edge N+1.
- Full FIFO: no push even if a pop occurs on the same edge; upstream sees one extra stall cycle.
- Simultaneous push and pop when not full: occupancy unchanged.
- Read response: one cycle of added latency, strictly in order.

## Configuration
- AVB16_PERF_CNT_EN defined:
  - Adds outputs perf_rd_cnt, perf_wr_cnt, perf_stall_cnt, each 32 bits, reset to 0.
  - perf_rd_cnt and perf_wr_cnt increment on read and write pushes respectively.
  - perf_stall_cnt increments each cycle a request is present with s_waitrequest=1.
  - All three counters saturate at 32'hFFFF_FFFF.
- AVB16_PERF_CNT_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Write passthrough: write addr 22'h000010, data 16'hA5A5, be_n 2'b00, m_waitrequest=0 → one write on m_* with the same fields one cycle later; s_waitrequest never 1.
- Fill: m_waitrequest=1, issue 5 writes with DEPTH=4 → 4 accepted, 5th stalled. Release m_waitrequest → 5th accepted one cycle after the first pop, and all 5 emerge in order.
- Read limit: MAX_RD=2, 3 reads, controller returns 16'h1111 then 16'h2222 with 3-cycle latency → 3rd read stalled until the first s_readdatavalid; s_readdata shows 1111 then 2222, each one cycle after m_readdatavalid.
- Mixed traffic: write lo, write hi, read lo, read hi (bridge sequence) → m_* order preserved, rd_out returns to 0.
- Reset with 3 queued entries → next cycle FIFO empty, m_chipselect=0, s_waitrequest=0.
- With AVB16_PERF_CNT_EN: the fill scenario → perf_wr_cnt=5 and perf_stall_cnt equals the number of stalled cycles.

Source files
------------

// File: rtl/avalon16_cmd_fifo.sv
// Buffered Avalon-MM 16-bit command stage: in-order command FIFO, outstanding-read limiter, registered read return.
// Define AVB16_PERF_CNT_EN to add saturating read/write/stall performance counters.
module avalon16_cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int MAX_RD = 4
) (
    input  logic        sdram_clk,
    input  logic        reset_n,
    input  logic [21:0] s_address,
    input  logic [1:0]  s_byteenable_n,
    input  logic        s_chipselect,
    input  logic        s_read_n,
    input  logic        s_write_n,
    input  logic [15:0] s_writedata,
    output logic        s_waitrequest,
    output logic [15:0] s_readdata,
    output logic        s_readdatavalid,
    output logic [21:0] m_address,
    output logic [1:0]  m_byteenable_n,
    output logic        m_chipselect,
    output logic        m_read_n,
    output logic        m_write_n,
    output logic [15:0] m_writedata,
    input  logic        m_waitrequest,
    input  logic [15:0] m_readdata,
    input  logic        m_readdatavalid
`ifdef AVB16_PERF_CNT_EN
    ,
    output logic [31:0] perf_rd_cnt,
    output logic [31:0] perf_wr_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [3:0] MAX_RD_C = 4'(MAX_RD);

    typedef struct packed {
        logic        is_write;
        logic [21:0] address;
        logic [1:0]  byteenable_n;
        logic [15:0] writedata;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [3:0]         rd_out;
    logic [21:0]        last_address;
    logic [15:0]        last_writedata;
    logic               full;
    logic               empty;
    logic               request;
    logic               is_write;
    logic               push;
    logic               pop;
    logic               rd_inc;

    assign request  = s_chipselect && (!s_read_n || !s_write_n);
    assign is_write = !s_write_n;
    assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign head     = mem[rd_ptr[AW-1:0]];

    // Stall never looks at m_waitrequest, so a full FIFO blocks a push even on a popping edge.
    assign s_waitrequest = !reset_n || full || (request && !is_write && (rd_out == MAX_RD_C));
    assign push          = request && !s_waitrequest;
    assign pop           = !empty && !m_waitrequest;
    assign rd_inc        = push && !is_write;

    always_ff @(posedge sdram_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{is_write:     is_write,
                                     address:      s_address,
                                     byteenable_n: s_byteenable_n,
                                     writedata:    is_write ? s_writedata : 16'h0000};
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            rd_out          <= 4'd0;
            last_address    <= 22'h0;
            last_writedata  <= 16'h0;
            s_readdatavalid <= 1'b0;
            s_readdata      <= 16'h0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + PTR_W'(1);
                last_address   <= head.address;
                last_writedata <= head.writedata;
            end
            // Late strobes after a reset must not wrap the counter below zero.
            if (rd_inc && !s_readdatavalid) begin
                rd_out <= rd_out + 4'd1;
            end else if (!rd_inc && s_readdatavalid && (rd_out != 4'd0)) begin
                rd_out <= rd_out - 4'd1;
            end
            s_readdatavalid <= m_readdatavalid;
            if (m_readdatavalid) begin
                s_readdata <= m_readdata;
            end
        end
    end

    always_comb begin
        m_chipselect   = !empty;
        m_read_n       = 1'b1;
        m_write_n      = 1'b1;
        m_byteenable_n = 2'b11;
        m_address      = last_address;
        m_writedata    = last_writedata;
        if (!empty) begin
            m_read_n       = head.is_write;
            m_write_n      = !head.is_write;
            m_byteenable_n = head.byteenable_n;
            m_address      = head.address;
            m_writedata    = head.writedata;
        end
    end

`ifdef AVB16_PERF_CNT_EN
    always_ff @(posedge sdram_clk) begin
        if (!reset_n) begin
            perf_rd_cnt    <= 32'd0;
            perf_wr_cnt    <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (rd_inc && (perf_rd_cnt != 32'hFFFF_FFFF)) begin
                perf_rd_cnt <= perf_rd_cnt + 32'd1;
            end
            if (push && is_write && (perf_wr_cnt != 32'hFFFF_FFFF)) begin
                perf_wr_cnt <= perf_wr_cnt + 32'd1;
            end
            if (request && s_waitrequest && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
